writeback_select_stage: RTL and testbench
=========================================

# writeback_select_stage

Registered, parametrised write-back stage for the pipelined core. It latches one instruction's results at the MEM/WB boundary and selects among four result sources: ALU, data memory, link address and immediate. It extracts and sign- or zero-extends sub-word loads, and presents the register-file write port (data, address, enable) one cycle later. Stall, flush and valid are handled so the hazard unit can freeze or kill the stage.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register index width.
- ZERO_REG_GUARD, 1, when 1 a write to register 0 is suppressed (regWrite forced 0).

Ports:
- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- inValid  input  1  upstream slot holds a real instruction.
- stall  input  1  hold stage contents; no capture.
- flush  input  1  kill the instruction being captured this edge.
- WbSel  input  2  source: 0 ALUResult, 1 DataMemOut, 2 LinkAddr, 3 ImmValue.
- ALUResult  input  DATA_W  ALU output.
- DataMemOut  input  DATA_W  raw aligned memory word.
- LinkAddr  input  DATA_W  PC+4 for jump-and-link.
- ImmValue  input  DATA_W  upper-immediate value.
- LoadSize  input  2  0 byte, 1 half, 2 word (32 b), 3 full DATA_W.
- LoadUnsigned  input  1  1 zero-extend, 0 sign-extend.
- ByteOff  input  log2(DATA_W/8)  byte offset of the load address within the word.
- RegWriteIn  input  1  instruction writes the register file.
- DestRegIn  input  REG_ADDR_W  destination register.
- regWriteData  output  DATA_W  selected, extended write data.
- regWriteAddr  output  REG_ADDR_W  destination register.
- regWrite  output  1  register-file write enable.
- outValid  output  1  stage holds a valid instruction.

## Operation
- Result select is combinational on the inputs and is captured into the output registers.
- WbSel=1 routes DataMemOut through the load extractor:
  - Byte: lane ByteOff is taken.
  - Half: lane ByteOff[msb:1] is taken; ByteOff[0] is ignored.
  - Word with DATA_W=64: lane ByteOff[msb] is taken.
  - The extracted field is extended to DATA_W by sign or zero according to LoadUnsigned.
  - LoadSize=3 passes DataMemOut unchanged.
  - LoadSize=2 with DATA_W=32 equals LoadSize=3.
- WbSel≠1 ignores LoadSize, LoadUnsigned and ByteOff.
- regWrite = captured RegWriteIn AND captured valid AND NOT (ZERO_REG_GUARD AND address==0).
- Capture priority at each posedge, highest first:
  1. reset
  2. flush
  3. stall
  4. normal capture
- Reset: all outputs 0 (regWriteData=0, regWriteAddr=0, regWrite=0, outValid=0).
- Flush (stall ignored): outValid=0 and regWrite=0; data and address registers may take any value, and the bench must not check them.
- Stall without flush: all outputs hold their previous values. A held regWrite=1 is permitted; the register file absorbs the repeated write.
- Normal: capture inputs; outValid=inValid. When inValid=0, regWrite=0.

## Timing
- Latency is exactly 1 cycle: inputs present before posedge N appear on the outputs after posedge N.
- Throughput is 1 instruction per cycle when not stalled.
- There is no combinational path from any input to any output.
- Reset asserted mid-stream clears the stage at the next edge regardless of stall or flush. The first capture occurs at the first edge with reset low.
- Stall held for K cycles holds the outputs for K edges. The inputs present on the edge where stall deasserts are then captured.

## Configuration
- Macro: WB_LOAD_EXT_EN.
- Defined: the sub-word extractor and extender are present, as described under Operation.
- Undefined: the extractor is absent. WbSel=1 passes DataMemOut unchanged for every LoadSize; LoadSize, LoadUnsigned and ByteOff are unused. All other behaviour is identical.

## Test plan
- Reset: hold reset 2 cycles with random inputs -> all outputs 0. Deassert reset, then drive WbSel=0, ALUResult=0x0000_1234, DestRegIn=7, RegWriteIn=1, inValid=1 -> one edge later regWriteData=0x0000_1234, regWriteAddr=7, regWrite=1, outValid=1.
- Source select: run a back-to-back stream of WbSel=2 (LinkAddr=0x0040_0008) then WbSel=3 (ImmValue=0xABCD_0000) -> outputs show 0x0040_0008 then 0xABCD_0000 on consecutive cycles.
- Loads (WB_LOAD_EXT_EN defined, DATA_W=32), all with DataMemOut=0x80FF_7F01:
  - byte, ByteOff=3, signed -> 0xFFFF_FF80
  - byte, ByteOff=3, unsigned -> 0x0000_0080
  - half, ByteOff=2, signed -> 0xFFFF_80FF
  - half, ByteOff=0, signed -> 0x0000_7F01
  - Without the macro, all four cases -> 0x80FF_7F01.
- Stall and flush:
  - Capture A (0x11), then assert stall for 3 cycles while driving B (0x22) -> outputs hold A.
  - Release stall -> B appears one edge later.
  - Assert stall and flush together -> outValid=0, regWrite=0.
- Zero register: DestRegIn=0, RegWriteIn=1, inValid=1 -> with ZERO_REG_GUARD=1, regWrite=0 and outValid=1; with ZERO_REG_GUARD=0, regWrite=1.
- DATA_W=64: DataMemOut=0xFFFF_FFFE_0000_0001, LoadSize=2, ByteOff=4, signed -> 0xFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/writeback_select_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | writeback_select_stage : MEM/WB result select, load extract, RF write port  |
// | Optional sub-word load extractor: define WB_LOAD_EXT_EN.                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module writeback_select_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inValid,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [1:0]                    WbSel,
  input  logic [DATA_W-1:0]             ALUResult,
  input  logic [DATA_W-1:0]             DataMemOut,
  input  logic [DATA_W-1:0]             LinkAddr,
  input  logic [DATA_W-1:0]             ImmValue,
  input  logic [1:0]                    LoadSize,
  input  logic                          LoadUnsigned,
  input  logic [$clog2(DATA_W/8)-1:0]   ByteOff,
  input  logic                          RegWriteIn,
  input  logic [REG_ADDR_W-1:0]         DestRegIn,
  output logic [DATA_W-1:0]             regWriteData,
  output logic [REG_ADDR_W-1:0]         regWriteAddr,
  output logic                          regWrite,
  output logic                          outValid
);

  localparam int OFF_W = $clog2(DATA_W/8);

  logic [DATA_W-1:0]     w_load_data;
  logic [DATA_W-1:0]     data_d;
  logic                  regWrite_d;
  logic                  w_zero_hit;
  logic [DATA_W-1:0]     data_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic                  regWrite_q;
  logic                  valid_q;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_word_ext;

  // Lane index is the byte offset scaled to a bit offset; halves drop ByteOff[0].
  assign w_byte = DataMemOut[{ByteOff, 3'b000} +: 8];
  assign w_half = DataMemOut[{ByteOff[OFF_W-1:1], 4'b0000} +: 16];

  generate
    if (DATA_W == 64) begin : g_word64
      logic [31:0] w_word;
      assign w_word     = DataMemOut[{ByteOff[OFF_W-1], 5'b00000} +: 32];
      assign w_word_ext = {{(DATA_W-32){w_word[31] & ~LoadUnsigned}}, w_word};
    end else begin : g_word32
      assign w_word_ext = DataMemOut;
    end
  endgenerate

  always_comb begin
    w_load_data = DataMemOut;
    case (LoadSize)
      2'd0:    w_load_data = {{(DATA_W-8){w_byte[7] & ~LoadUnsigned}}, w_byte};
      2'd1:    w_load_data = {{(DATA_W-16){w_half[15] & ~LoadUnsigned}}, w_half};
      2'd2:    w_load_data = w_word_ext;
      default: w_load_data = DataMemOut;
    endcase
  end
`else
  logic w_unused_load;
  assign w_unused_load = ^{LoadSize, LoadUnsigned, ByteOff};
  assign w_load_data   = DataMemOut;
`endif

  always_comb begin
    data_d = ALUResult;
    case (WbSel)
      2'd1:    data_d = w_load_data;
      2'd2:    data_d = LinkAddr;
      2'd3:    data_d = ImmValue;
      default: data_d = ALUResult;
    endcase
  end

  assign w_zero_hit = (ZERO_REG_GUARD != 0) && (DestRegIn == '0);
  assign regWrite_d = RegWriteIn & inValid & ~w_zero_hit;

  // Flush only kills the valid/enable bits; data and address are don't-care then.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      addr_q     <= '0;
      regWrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (flush) begin
      regWrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!stall) begin
      data_q     <= data_d;
      addr_q     <= DestRegIn;
      regWrite_q <= regWrite_d;
      valid_q    <= inValid;
    end
  end

  assign regWriteData = data_q;
  assign regWriteAddr = addr_q;
  assign regWrite     = regWrite_q;
  assign outValid     = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_select_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_writeback_select_stage : directed scoreboard bench for the WB stage      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_writeback_select_stage;

  logic        clk;
  logic        reset;
  logic        inValid, stall, flush;
  logic [1:0]  WbSel, LoadSize;
  logic        LoadUnsigned, RegWriteIn;
  logic [31:0] ALUResult, DataMemOut, LinkAddr, ImmValue;
  logic [1:0]  ByteOff;
  logic [4:0]  DestRegIn;
  logic [31:0] regWriteData, ng_data;
  logic [4:0]  regWriteAddr, ng_addr;
  logic        regWrite, outValid, ng_we, ng_vld;

  logic [63:0] ALU64, Mem64, Link64, Imm64, data64;
  logic [2:0]  ByteOff64;
  logic [4:0]  addr64;
  logic        we64, vld64;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic        vld;
    logic        chk_data;
  } exp_t;
  exp_t sb[$];

  writeback_select_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_GUARD(1)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .stall(stall), .flush(flush),
    .WbSel(WbSel), .ALUResult(ALUResult), .DataMemOut(DataMemOut),
    .LinkAddr(LinkAddr), .ImmValue(ImmValue), .LoadSize(LoadSize),
    .LoadUnsigned(LoadUnsigned), .ByteOff(ByteOff), .RegWriteIn(RegWriteIn),
    .DestRegIn(DestRegIn), .regWriteData(regWriteData), .regWriteAddr(regWriteAddr),
    .regWrite(regWrite), .outValid(outValid)
  );

  writeback_select_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_GUARD(0)) dut_ng (
    .clk(clk), .reset(reset), .inValid(inValid), .stall(stall), .flush(flush),
    .WbSel(WbSel), .ALUResult(ALUResult), .DataMemOut(DataMemOut),
    .LinkAddr(LinkAddr), .ImmValue(ImmValue), .LoadSize(LoadSize),
    .LoadUnsigned(LoadUnsigned), .ByteOff(ByteOff), .RegWriteIn(RegWriteIn),
    .DestRegIn(DestRegIn), .regWriteData(ng_data), .regWriteAddr(ng_addr),
    .regWrite(ng_we), .outValid(ng_vld)
  );

  writeback_select_stage #(.DATA_W(64), .REG_ADDR_W(5), .ZERO_REG_GUARD(1)) dut64 (
    .clk(clk), .reset(reset), .inValid(inValid), .stall(stall), .flush(flush),
    .WbSel(WbSel), .ALUResult(ALU64), .DataMemOut(Mem64),
    .LinkAddr(Link64), .ImmValue(Imm64), .LoadSize(LoadSize),
    .LoadUnsigned(LoadUnsigned), .ByteOff(ByteOff64), .RegWriteIn(RegWriteIn),
    .DestRegIn(DestRegIn), .regWriteData(data64), .regWriteAddr(addr64),
    .regWrite(we64), .outValid(vld64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] d, input logic [4:0] a, input logic we,
                            input logic vld, input logic chk);
    exp_t e;
    e.data = d; e.addr = a; e.we = we; e.vld = vld; e.chk_data = chk;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare the primary DUT against the oldest expectation.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".outValid"}, 64'(outValid), 64'(e.vld));
      check({tag, ".regWrite"}, 64'(regWrite), 64'(e.we));
      if (e.chk_data) begin
        check({tag, ".data"}, 64'(regWriteData), 64'(e.data));
        check({tag, ".addr"}, 64'(regWriteAddr), 64'(e.addr));
      end
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] val, input logic [4:0] rd);
    WbSel = sel; DestRegIn = rd; RegWriteIn = 1'b1; inValid = 1'b1;
    case (sel)
      2'd0: ALUResult = val;
      2'd1: DataMemOut = val;
      2'd2: LinkAddr = val;
      default: ImmValue = val;
    endcase
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [1:0] off,
                      input logic [31:0] exp_ext, input string tag);
    WbSel = 2'd1; DataMemOut = 32'h80FF_7F01; LoadSize = sz; LoadUnsigned = uns;
    ByteOff = off; DestRegIn = 5'd10; RegWriteIn = 1'b1; inValid = 1'b1;
`ifdef WB_LOAD_EXT_EN
    expect_out(exp_ext, 5'd10, 1'b1, 1'b1, 1'b1);
`else
    expect_out(32'h80FF_7F01, 5'd10, 1'b1, 1'b1, 1'b1);
`endif
    tick(tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    ALU64 = '0; Mem64 = '0; Link64 = '0; Imm64 = '0; ByteOff64 = '0;
    LoadSize = 2'd2; LoadUnsigned = 1'b0; ByteOff = 2'd0;

    // Reset with random inputs for two edges
    for (int i = 0; i < 2; i++) begin
      inValid = 1'($urandom); WbSel = 2'($urandom); RegWriteIn = 1'($urandom);
      ALUResult = $urandom; DataMemOut = $urandom; LinkAddr = $urandom;
      ImmValue = $urandom; DestRegIn = 5'($urandom);
      expect_out(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick("reset");
    end
    check("reset.dut64_data", data64, 64'h0);

    reset = 1'b0;
    drive(2'd0, 32'h0000_1234, 5'd7);
    expect_out(32'h0000_1234, 5'd7, 1'b1, 1'b1, 1'b1);
    tick("first_alu");

    drive(2'd2, 32'h0040_0008, 5'd3);
    expect_out(32'h0040_0008, 5'd3, 1'b1, 1'b1, 1'b1);
    tick("link");
    drive(2'd3, 32'hABCD_0000, 5'd4);
    expect_out(32'hABCD_0000, 5'd4, 1'b1, 1'b1, 1'b1);
    tick("imm");

    load(2'd0, 1'b0, 2'd3, 32'hFFFF_FF80, "ld_byte_s3");
    load(2'd0, 1'b1, 2'd3, 32'h0000_0080, "ld_byte_u3");
    load(2'd1, 1'b0, 2'd2, 32'hFFFF_80FF, "ld_half_s2");
    load(2'd1, 1'b0, 2'd0, 32'h0000_7F01, "ld_half_s0");
    load(2'd3, 1'b0, 2'd1, 32'h80FF_7F01, "ld_full");

    // 64-bit instance word load alongside a 32-bit word load (pass-through)
    Mem64 = 64'hFFFF_FFFE_0000_0001; ByteOff64 = 3'd4;
    load(2'd2, 1'b0, 2'd0, 32'h80FF_7F01, "ld_word32");
`ifdef WB_LOAD_EXT_EN
    check("ld_word64", data64, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    check("ld_word64", data64, 64'hFFFF_FFFE_0000_0001);
`endif

    // Stall holds A while B is presented, then B is captured on release
    drive(2'd0, 32'h0000_0011, 5'd5);
    expect_out(32'h11, 5'd5, 1'b1, 1'b1, 1'b1);
    tick("stall_A");
    stall = 1'b1;
    drive(2'd0, 32'h0000_0022, 5'd6);
    for (int i = 0; i < 3; i++) begin
      expect_out(32'h11, 5'd5, 1'b1, 1'b1, 1'b1);
      tick("stall_hold");
    end
    stall = 1'b0;
    expect_out(32'h22, 5'd6, 1'b1, 1'b1, 1'b1);
    tick("stall_release_B");

    stall = 1'b1; flush = 1'b1;
    drive(2'd0, 32'h0000_0033, 5'd8);
    expect_out(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick("flush_stall");
    stall = 1'b0; flush = 1'b0;

    // inValid=0 suppresses the write even with RegWriteIn=1
    drive(2'd0, 32'h0000_0044, 5'd9);
    inValid = 1'b0;
    expect_out(32'h44, 5'd9, 1'b0, 1'b0, 1'b1);
    tick("invalid");

    drive(2'd0, 32'h0000_0055, 5'd0);
    expect_out(32'h55, 5'd0, 1'b0, 1'b1, 1'b1);
    tick("zero_reg_guard");
    check("zero_reg_noguard.regWrite", 64'(ng_we), 64'h1);
    check("zero_reg_noguard.outValid", 64'(ng_vld), 64'h1);

    // Mid-stream reset wins over stall and flush
    drive(2'd0, 32'h0000_0066, 5'd11);
    expect_out(32'h66, 5'd11, 1'b1, 1'b1, 1'b1);
    tick("pre_reset");
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    expect_out(32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick("mid_reset");
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(2'd3, 32'h7777_0000, 5'd12);
    expect_out(32'h7777_0000, 5'd12, 1'b1, 1'b1, 1'b1);
    tick("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
